// File: rtl/game_flow_ctrl.sv
// Game-progression controller: sequences title/play/pause/death/level/world/win/lose screens,
// owns level, world and lives counters, and freezes player movement outside active play.
module game_flow_ctrl #(
    parameter int LEVELS_PER_WORLD = 3,
    parameter int NUM_WORLDS       = 6,
    parameter int START_LIVES      = 7,
    parameter int MAX_LIVES        = 7,
    parameter int LIFE_W           = 3,
    parameter int HOLD_W           = 24,
    parameter int DISPLAY_HOLD     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_btn,
    input  logic              continue_btn,
    input  logic              pause_btn,
    input  logic              player_dead,
    input  logic              level_complete,
    output logic [2:0]        level,
    output logic [2:0]        world,
    output logic [LIFE_W-1:0] lives,
    output logic [2:0]        screen,
    output logic              player_disable,
    output logic              reset_select
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PLAY       = 4'd1,
        S_DEATH      = 4'd2,
        S_DEATH_WAIT = 4'd3,
        S_PAUSE      = 4'd4,
        S_LEVEL_UP   = 4'd5,
        S_WORLD_UP   = 4'd6,
        S_WIN        = 4'd7,
        S_LOSE       = 4'd8,
        S_RESET      = 4'd9
    } state_t;

    localparam logic [2:0]        LAST_LEVEL = 3'(LEVELS_PER_WORLD);
    localparam logic [2:0]        LAST_WORLD = 3'(NUM_WORLDS);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] LIVES_CAP  = LIFE_W'(MAX_LIVES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((DISPLAY_HOLD == 0) ? 0 : DISPLAY_HOLD - 1);

    state_t            state, state_nxt;
    logic [2:0]        level_nxt, world_nxt;
    logic [LIFE_W-1:0] lives_nxt;
    logic [2:0]        screen_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        btn_cur, btn_prev;
    logic              start_edge, continue_edge, pause_edge;
    logic              hold_done;

    // Bit order: {pause, continue, start}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_cur  <= 3'b000;
            btn_prev <= 3'b000;
        end else begin
            btn_cur  <= {pause_btn, continue_btn, start_btn};
            btn_prev <= btn_cur;
        end
    end

    assign start_edge    = btn_cur[0] & ~btn_prev[0];
    assign continue_edge = btn_cur[1] & ~btn_prev[1];
    assign pause_edge    = btn_cur[2] & ~btn_prev[2];
    assign hold_done     = (DISPLAY_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        world_nxt = world;
        lives_nxt = lives;
        case (state)
            S_IDLE: begin
                level_nxt = 3'd1;
                world_nxt = 3'd1;
                lives_nxt = LIVES_INIT;
                if (start_edge) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                // Death outranks everything, so a simultaneous level_complete is dropped
                if (player_dead) begin
                    state_nxt = S_DEATH;
                    if (lives != '0) begin
                        lives_nxt = lives - LIFE_W'(1);
                    end
                end else if (pause_edge) begin
                    state_nxt = S_PAUSE;
                end else if (level_complete) begin
                    if (level < LAST_LEVEL) begin
                        state_nxt = S_LEVEL_UP;
                        level_nxt = level + 3'd1;
                    end else if (world < LAST_WORLD) begin
                        state_nxt = S_WORLD_UP;
                        world_nxt = world + 3'd1;
                        level_nxt = 3'd1;
                        if (lives < LIVES_CAP) begin
                            lives_nxt = lives + LIFE_W'(1);
                        end
                    end else begin
                        state_nxt = S_WIN;
                    end
                end
            end
            S_DEATH: begin
                state_nxt = (lives == '0) ? S_LOSE : S_DEATH_WAIT;
            end
            S_DEATH_WAIT: begin
                if (!player_dead) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (pause_edge) begin
                    state_nxt = S_PLAY;
                end
            end
            S_LEVEL_UP, S_WORLD_UP: begin
                if (continue_edge || hold_done) begin
                    state_nxt = S_PLAY;
                end
            end
            S_WIN, S_LOSE: begin
                if (continue_edge) begin
                    state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                // Preload start values so IDLE already shows them on entry
                state_nxt = S_IDLE;
                level_nxt = 3'd1;
                world_nxt = 3'd1;
                lives_nxt = LIVES_INIT;
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    always_comb begin
        screen_nxt = 3'd0;
        case (state_nxt)
            S_IDLE, S_PLAY, S_DEATH, S_DEATH_WAIT: screen_nxt = 3'd1;
            S_LOSE:                                screen_nxt = 3'd2;
            S_WIN:                                 screen_nxt = 3'd3;
            S_LEVEL_UP:                            screen_nxt = 3'd4;
            S_WORLD_UP:                            screen_nxt = 3'd5;
            S_PAUSE:                               screen_nxt = 3'd6;
            default:                               screen_nxt = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level          <= 3'd1;
            world          <= 3'd1;
            lives          <= LIVES_INIT;
            screen         <= 3'd1;
            player_disable <= 1'b1;
            reset_select   <= 1'b0;
            hold_cnt       <= '0;
        end else begin
            level          <= level_nxt;
            world          <= world_nxt;
            lives          <= lives_nxt;
            screen         <= screen_nxt;
            player_disable <= !(state_nxt inside {S_PLAY, S_DEATH, S_DEATH_WAIT});
            reset_select   <= (state_nxt == S_RESET);
            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (state == S_LEVEL_UP || state == S_WORLD_UP) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: instance 0 uses default geometry, instance 1 uses
// START_LIVES=2 and DISPLAY_HOLD=10.
module tb_game_flow_ctrl;

    localparam int F_SCREEN = 0;
    localparam int F_PDIS   = 1;
    localparam int F_RSEL   = 2;
    localparam int F_LEVEL  = 3;
    localparam int F_WORLD  = 4;
    localparam int F_LIVES  = 5;

    typedef struct {
        int    idx;
        int    field;
        int    value;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st[2];
    logic co[2];
    logic pa[2];
    logic pd[2];
    logic lc[2];
    logic [2:0] lvl[2];
    logic [2:0] wld[2];
    logic [2:0] lvs[2];
    logic [2:0] scr[2];
    logic       pdis[2];
    logic       rsel[2];

    exp_t sb[$];
    int   passes = 0;
    int   total  = 0;
    int   fails  = 0;
    int   el = 1;
    int   ew = 1;
    int   elv = 7;

    always #5 clk = ~clk;

    game_flow_ctrl dut_a (
        .clk(clk), .rst(rst),
        .start_btn(st[0]), .continue_btn(co[0]), .pause_btn(pa[0]),
        .player_dead(pd[0]), .level_complete(lc[0]),
        .level(lvl[0]), .world(wld[0]), .lives(lvs[0]), .screen(scr[0]),
        .player_disable(pdis[0]), .reset_select(rsel[0])
    );

    game_flow_ctrl #(.START_LIVES(2), .DISPLAY_HOLD(10)) dut_b (
        .clk(clk), .rst(rst),
        .start_btn(st[1]), .continue_btn(co[1]), .pause_btn(pa[1]),
        .player_dead(pd[1]), .level_complete(lc[1]),
        .level(lvl[1]), .world(wld[1]), .lives(lvs[1]), .screen(scr[1]),
        .player_disable(pdis[1]), .reset_select(rsel[1])
    );

    function automatic int obs(int i, int f);
        case (f)
            F_SCREEN: return int'(scr[i]);
            F_PDIS:   return int'(pdis[i]);
            F_RSEL:   return int'(rsel[i]);
            F_LEVEL:  return int'(lvl[i]);
            F_WORLD:  return int'(wld[i]);
            default:  return int'(lvs[i]);
        endcase
    endfunction

    task automatic check(string tag, int o, int e);
        total++;
        assert (o === e) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, o, e);
        end
    endtask

    task automatic expect_out(int i, int f, int v, string tag);
        exp_t e;
        e.idx = i; e.field = f; e.value = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_scr(int i, int s, int pdv, string tag);
        expect_out(i, F_SCREEN, s, {tag, ".screen"});
        expect_out(i, F_PDIS, pdv, {tag, ".player_disable"});
    endtask

    task automatic expect_cnt(int i, int l, int w, int lv, string tag);
        expect_out(i, F_LEVEL, l, {tag, ".level"});
        expect_out(i, F_WORLD, w, {tag, ".world"});
        expect_out(i, F_LIVES, lv, {tag, ".lives"});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.idx, e.field), e.value);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_st(int i);
        st[i] = 1'b1; step(2); st[i] = 1'b0; step(1);
    endtask

    task automatic press_co(int i);
        co[i] = 1'b1; step(2); co[i] = 1'b0; step(1);
    endtask

    task automatic press_pa(int i);
        pa[i] = 1'b1; step(2); pa[i] = 1'b0; step(1);
    endtask

    // Reference model for instance 0: 3 levels per world, 6 worlds, lives cap 7
    task automatic advance_a(string tag);
        int es;
        if (el < 3) begin
            el++;
            es = 4;
        end else if (ew < 6) begin
            ew++;
            el = 1;
            if (elv < 7) elv++;
            es = 5;
        end else begin
            es = 3;
        end
        expect_scr(0, es, 1, tag);
        expect_cnt(0, el, ew, elv, tag);
        lc[0] = 1'b1; step(1); lc[0] = 1'b0;
        drain();
        if (es != 3) begin
            press_co(0);
            expect_scr(0, 1, 0, {tag, ".resume"});
            drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; co[i] = 1'b0; pa[i] = 1'b0; pd[i] = 1'b0; lc[i] = 1'b0;
        end
        rst = 1'b0;
        step(2);
        for (int i = 0; i < 2; i++) begin
            expect_scr(i, 1, 1, "reset");
            expect_out(i, F_RSEL, 0, "reset.reset_select");
            expect_cnt(i, 1, 1, (i == 0) ? 7 : 2, "reset");
        end
        drain();
        rst = 1'b1;
        step(1);

        // Held start: one transition, two cycles after the press
        st[0] = 1'b1;
        step(1);
        expect_scr(0, 1, 1, "start_1cyc");
        drain();
        step(1);
        expect_scr(0, 1, 0, "start_2cyc");
        expect_cnt(0, 1, 1, 7, "start_2cyc");
        drain();
        step(3);
        st[0] = 1'b0;
        step(1);
        expect_scr(0, 1, 0, "start_held");
        drain();

        advance_a("lvl_up1");
        advance_a("lvl_up2");
        advance_a("world_up1");

        // Death and level_complete together: death wins
        pd[0] = 1'b1; lc[0] = 1'b1;
        elv = 6;
        expect_scr(0, 1, 0, "dead_and_done");
        expect_cnt(0, 1, 2, 6, "dead_and_done");
        step(1);
        lc[0] = 1'b0;
        drain();
        step(1);
        pd[0] = 1'b0;
        step(1);
        expect_cnt(0, 1, 2, 6, "after_death");
        drain();

        press_pa(0);
        expect_scr(0, 6, 1, "paused");
        drain();
        pd[0] = 1'b1; lc[0] = 1'b1;
        step(2);
        pd[0] = 1'b0; lc[0] = 1'b0;
        step(1);
        expect_scr(0, 6, 1, "pause_ignores");
        expect_cnt(0, 1, 2, 6, "pause_ignores");
        drain();
        press_pa(0);
        expect_scr(0, 1, 0, "unpaused");
        drain();

        press_co(0);
        press_st(0);
        expect_scr(0, 1, 0, "stray_buttons");
        expect_cnt(0, 1, 2, 6, "stray_buttons");
        drain();

        for (int k = 0; k < 15; k++) begin
            advance_a($sformatf("adv%0d", k));
        end

        co[0] = 1'b1;
        step(2);
        expect_scr(0, 0, 1, "win_reset");
        expect_out(0, F_RSEL, 1, "win_reset.reset_select");
        drain();
        step(1);
        expect_scr(0, 1, 1, "win_idle");
        expect_out(0, F_RSEL, 0, "win_idle.reset_select");
        expect_cnt(0, 1, 1, 7, "win_idle");
        drain();
        co[0] = 1'b0;
        step(1);

        // Instance 1: timed auto-continue and game over
        press_st(1);
        expect_scr(1, 1, 0, "b_play");
        drain();
        lc[1] = 1'b1;
        step(1);
        lc[1] = 1'b0;
        expect_scr(1, 4, 1, "b_lvl_up");
        expect_cnt(1, 2, 1, 2, "b_lvl_up");
        drain();
        n = 0;
        while (scr[1] == 3'd4 && n < 50) begin
            n++;
            step(1);
        end
        check("b_hold_len", n, 10);
        expect_scr(1, 1, 0, "b_hold_exit");
        drain();

        pd[1] = 1'b1;
        step(1);
        expect_cnt(1, 2, 1, 1, "b_kill1");
        expect_scr(1, 1, 0, "b_kill1");
        drain();
        pd[1] = 1'b0;
        step(2);
        pd[1] = 1'b1;
        step(1);
        expect_out(1, F_LIVES, 0, "b_kill2.lives");
        drain();
        step(1);
        expect_scr(1, 2, 1, "b_lose");
        expect_out(1, F_LIVES, 0, "b_lose.lives");
        drain();
        pd[1] = 1'b0;
        co[1] = 1'b1;
        step(2);
        expect_scr(1, 0, 1, "b_reset");
        expect_out(1, F_RSEL, 1, "b_reset.reset_select");
        drain();
        step(1);
        expect_out(1, F_RSEL, 0, "b_idle.reset_select");
        expect_scr(1, 1, 1, "b_idle");
        expect_out(1, F_LIVES, 2, "b_idle.lives");
        drain();
        co[1] = 1'b0;
        step(2);
        expect_out(1, F_RSEL, 0, "b_pulse_end.reset_select");
        drain();

        // Mid-game async reset with start still held
        st[0] = 1'b1;
        step(2);
        expect_scr(0, 1, 0, "pre_rst_play");
        drain();
        rst = 1'b0;
        #1;
        expect_scr(0, 1, 1, "async_rst");
        expect_cnt(0, 1, 1, 7, "async_rst");
        drain();
        #1;
        rst = 1'b1;
        step(1);
        expect_scr(0, 1, 1, "post_rst_1cyc");
        drain();
        step(1);
        expect_scr(0, 1, 0, "post_rst_edge");
        drain();
        st[0] = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
